// File: rtl/rf_scoreboard_pkg.sv
// Shared sizing for the register-file scoreboard: GPR count, counter width,
// GPR address width and the saturation value of a pending counter.
package rf_scoreboard_pkg;
  localparam int SB_NREG  = 32;
  localparam int SB_CNT_W = 2;
  localparam int GPR_AW   = 5;
  localparam int CNT_MAX  = (1 << SB_CNT_W) - 1;
endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// One saturating up/down pending-write counter; err pulses when an unmatched
// inc hits max or an unmatched dec hits zero (value holds in both cases).
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic up, dn;
  assign up  = inc & ~dec;
  assign dn  = dec & ~inc;
  // clr outranks everything, so a flushed cycle can never raise an error
  assign err = ~clr & ((up & (cnt == MAX)) | (dn & (cnt == '0)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (up && cnt != MAX)   cnt <= cnt + 1'b1;
    else if (dn && cnt != '0)    cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/rf_scoreboard.sv
// GPR write scoreboard / issue interlock: per-register pending counters,
// busy lookup with retire write-through bypass, and the ID stall decision.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int NREG  = SB_NREG,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              issue_fire,
  input  logic              issue_we,
  input  logic [GPR_AW-1:0] issue_dest,
  input  logic              retire_fire,
  input  logic [GPR_AW-1:0] retire_dest,
  input  logic              flush,
  input  logic [GPR_AW-1:0] src1_addr,
  input  logic [GPR_AW-1:0] src2_addr,
  input  logic              src1_fwd_ok,
  input  logic              src2_fwd_ok,
  output logic              src1_busy,
  output logic              src2_busy,
  output logic              ds_stall,
  output logic              dest_full,
  output logic              sb_err
);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            err_v;

  assign cnt[0]   = '0;
  assign err_v[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic inc, dec;
    assign inc = issue_fire & issue_we & (issue_dest == GPR_AW'(r));
    assign dec = retire_fire & (retire_dest == GPR_AW'(r));
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (inc),
      .dec    (dec),
      .clr    (flush),
      .cnt    (cnt[r]),
      .err    (err_v[r])
    );
  end

  logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt;
  logic             dec1, dec2, dec_dest;

  assign src1_cnt = (32'(src1_addr)  < NREG) ? cnt[src1_addr]  : '0;
  assign src2_cnt = (32'(src2_addr)  < NREG) ? cnt[src2_addr]  : '0;
  assign dest_cnt = (32'(issue_dest) < NREG) ? cnt[issue_dest] : '0;

  assign dec1     = retire_fire & (retire_dest == src1_addr)  & (src1_addr  != '0);
  assign dec2     = retire_fire & (retire_dest == src2_addr)  & (src2_addr  != '0);
  assign dec_dest = retire_fire & (retire_dest == issue_dest) & (issue_dest != '0);

  // a register committing this cycle reads through the RF, so it is not busy
  assign src1_busy = (src1_cnt - CNT_W'(dec1)) != '0;
  assign src2_busy = (src2_cnt - CNT_W'(dec2)) != '0;
  assign dest_full = issue_we & (issue_dest != '0) & (dest_cnt == CMAX) & ~dec_dest;
  assign ds_stall  = (src1_busy & ~src1_fwd_ok) | (src2_busy & ~src2_fwd_ok) | dest_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     sb_err <= 1'b0;
    else if (|err_v) sb_err <= 1'b1;
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed vector table, hand-written reset sequence,
// then a randomized phase checked against a reference counter model.
module tb_rf_scoreboard;
  logic       clk = 1'b0;
  logic       resetn;
  logic       issue_fire, issue_we, retire_fire, flush;
  logic [4:0] issue_dest, retire_dest, src1_addr, src2_addr;
  logic       src1_fwd_ok, src2_fwd_ok;
  logic       src1_busy, src2_busy, ds_stall, dest_full, sb_err;

  int total = 0;
  int bad   = 0;

  rf_scoreboard dut (
    .clk         (clk),
    .resetn      (resetn),
    .issue_fire  (issue_fire),
    .issue_we    (issue_we),
    .issue_dest  (issue_dest),
    .retire_fire (retire_fire),
    .retire_dest (retire_dest),
    .flush       (flush),
    .src1_addr   (src1_addr),
    .src2_addr   (src2_addr),
    .src1_fwd_ok (src1_fwd_ok),
    .src2_fwd_ok (src2_fwd_ok),
    .src1_busy   (src1_busy),
    .src2_busy   (src2_busy),
    .ds_stall    (ds_stall),
    .dest_full   (dest_full),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ifire, iwe;
    logic [4:0] idest;
    logic       rfire;
    logic [4:0] rdest;
    logic       fl;
    logic [4:0] s1, s2;
    logic       f1, f2;
    logic [4:0] exp;  // {src1_busy, src2_busy, ds_stall, dest_full, sb_err}
  } vec_t;

  vec_t       vt[$];
  logic [4:0] exp_q[$];
  logic [1:0] mcnt[32];
  logic       merr;

  function automatic vec_t mk(input logic ifire, input logic iwe, input int idest,
                              input logic rfire, input int rdest, input logic fl,
                              input int s1, input int s2, input logic f1, input logic f2,
                              input logic [4:0] exp);
    vec_t v;
    v.ifire = ifire; v.iwe = iwe; v.idest = 5'(idest);
    v.rfire = rfire; v.rdest = 5'(rdest); v.fl = fl;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.f1 = f1; v.f2 = f2; v.exp = exp;
    return v;
  endfunction

  function automatic logic [4:0] dut_out();
    return {src1_busy, src2_busy, ds_stall, dest_full, sb_err};
  endfunction

  task automatic drive(input vec_t v);
    issue_fire = v.ifire; issue_we = v.iwe; issue_dest = v.idest;
    retire_fire = v.rfire; retire_dest = v.rdest; flush = v.fl;
    src1_addr = v.s1; src2_addr = v.s2; src1_fwd_ok = v.f1; src2_fwd_ok = v.f2;
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {b1,b2,stall,full,err}=%b want %b", name, got, exp);
    end
  endtask

  // reference model: expected outputs for the inputs currently driven
  function automatic logic [4:0] model_out();
    logic [1:0] c1, c2, cd;
    logic d1, d2, dd, b1, b2, full;
    c1 = mcnt[src1_addr]; c2 = mcnt[src2_addr]; cd = mcnt[issue_dest];
    d1 = retire_fire && retire_dest == src1_addr && src1_addr != 0;
    d2 = retire_fire && retire_dest == src2_addr && src2_addr != 0;
    dd = retire_fire && retire_dest == issue_dest;
    b1 = (c1 - {1'b0, d1}) != 2'd0;
    b2 = (c2 - {1'b0, d2}) != 2'd0;
    full = issue_we && issue_dest != 0 && cd == 2'd3 && !dd;
    return {b1, b2, (b1 && !src1_fwd_ok) || (b2 && !src2_fwd_ok) || full, full, merr};
  endfunction

  task automatic model_step();
    for (int r = 1; r < 32; r++) begin
      logic inc, dec;
      inc = issue_fire && issue_we && issue_dest == 5'(r);
      dec = retire_fire && retire_dest == 5'(r);
      if (flush) mcnt[r] = 2'd0;
      else if (inc && !dec) begin
        if (mcnt[r] == 2'd3) merr = 1'b1; else mcnt[r] = mcnt[r] + 2'd1;
      end else if (dec && !inc) begin
        if (mcnt[r] == 2'd0) merr = 1'b1; else mcnt[r] = mcnt[r] - 2'd1;
      end
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    drive(idle);
    resetn = 1'b0;
    #2;
    check("reset_outputs", dut_out(), 5'b00000);

    // r0 is never tracked
    vt.push_back(mk(0,0,0, 0,0, 0, 5,0, 0,0, 5'b00000));
    vt.push_back(mk(1,1,0, 0,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(0,0,0, 1,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(0,0,0, 0,0, 0, 0,0, 0,0, 5'b00000));
    // load-use on r8
    vt.push_back(mk(1,1,8, 0,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(0,0,0, 0,0, 0, 8,0, 0,0, 5'b10100));
    vt.push_back(mk(0,0,0, 0,0, 0, 8,0, 1,0, 5'b10000));
    // retire bypass on r8 and r3
    vt.push_back(mk(1,1,3, 1,8, 0, 8,0, 0,0, 5'b00000));
    vt.push_back(mk(0,0,0, 1,3, 0, 0,3, 0,0, 5'b00000));
    vt.push_back(mk(0,0,0, 0,0, 0, 8,3, 0,0, 5'b00000));
    // fill r4 to max, then simultaneous issue+retire
    vt.push_back(mk(1,1,4, 0,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(1,1,4, 0,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(1,1,4, 0,0, 0, 4,0, 1,0, 5'b10000));
    vt.push_back(mk(1,1,4, 1,4, 0, 4,0, 1,0, 5'b10000));
    vt.push_back(mk(0,0,0, 0,0, 0, 4,0, 0,0, 5'b10100));
    // saturate r9 and force an issue anyway
    vt.push_back(mk(1,1,9, 0,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(1,1,9, 0,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(1,1,9, 0,0, 0, 0,0, 0,0, 5'b00000));
    vt.push_back(mk(0,1,9, 0,0, 0, 9,0, 1,0, 5'b10110));
    vt.push_back(mk(1,1,9, 0,0, 0, 0,0, 0,0, 5'b00110));
    vt.push_back(mk(0,0,0, 0,0, 0, 9,0, 1,0, 5'b10001));
    vt.push_back(mk(0,1,9, 0,0, 0, 9,4, 1,1, 5'b11111));
    // flush with r2=2, r7=1 plus a discarded issue to r7
    vt.push_back(mk(1,1,2, 0,0, 0, 0,0, 0,0, 5'b00001));
    vt.push_back(mk(1,1,2, 0,0, 0, 0,0, 0,0, 5'b00001));
    vt.push_back(mk(1,1,7, 0,0, 0, 0,0, 0,0, 5'b00001));
    vt.push_back(mk(1,1,7, 0,0, 1, 7,2, 0,1, 5'b11101));
    vt.push_back(mk(0,0,0, 0,0, 0, 7,2, 0,0, 5'b00001));
    vt.push_back(mk(0,1,9, 0,0, 0, 9,4, 0,0, 5'b00001));

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check($sformatf("vec%0d", i), dut_out(), vt[i].exp);
    end

    // asynchronous reset mid-cycle with r5 pending twice (sb_err is set here)
    @(negedge clk); drive(mk(1,1,5, 0,0, 0, 0,0, 0,0, 5'b0));
    @(negedge clk); drive(mk(1,1,5, 0,0, 0, 0,0, 0,0, 5'b0));
    @(negedge clk); drive(mk(0,0,0, 0,0, 0, 5,0, 0,0, 5'b0));
    #1;
    check("pre_reset_r5", dut_out(), 5'b10101);
    #1 resetn = 1'b0;
    #1;
    check("async_reset", dut_out(), 5'b00000);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_reset_r5", dut_out(), 5'b00000);

    // randomized scoreboard phase against the reference model
    for (int r = 0; r < 32; r++) mcnt[r] = 2'd0;
    merr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [4:0] e;
      @(negedge clk);
      issue_fire  = $urandom_range(0, 1) != 0;
      issue_we    = $urandom_range(0, 3) != 0;
      issue_dest  = 5'($urandom_range(0, 5));
      retire_fire = $urandom_range(0, 2) == 0;
      retire_dest = 5'($urandom_range(0, 5));
      flush       = $urandom_range(0, 24) == 0;
      src1_addr   = 5'($urandom_range(0, 5));
      src2_addr   = 5'($urandom_range(0, 5));
      src1_fwd_ok = $urandom_range(0, 1) != 0;
      src2_fwd_ok = $urandom_range(0, 1) != 0;
      exp_q.push_back(model_out());
      #1;
      e = exp_q.pop_front();
      check($sformatf("rand%0d", i), dut_out(), e);
      @(posedge clk);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file scoreboard and issue interlock for the 5-stage MIPS pipeline. It sits beside decode and tracks every in-flight GPR write from the moment an instruction leaves ID until the writeback stage commits it through the single RF write port. It uses per-register pending counters and the forwarding network's availability flags to decide whether ID may issue. It is the sequencing authority for RF write ordering; the writeback stage itself stays a pure pipeline register.

## Interface
Parameters:
- NREG, 32, number of architectural GPRs tracked (r0 never tracked)
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2^CNT_W-1 (3 = EX/MEM/WB)

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- issue_fire  in  1  ID→EX transfer this cycle (ds_to_es_valid & es_allowin)
- issue_we  in  1  issuing instruction writes a GPR
- issue_dest  in  5  destination GPR of issuing instruction
- retire_fire  in  1  writeback commits a GPR write this cycle (ws_valid & rf_we)
- retire_dest  in  5  GPR being written by writeback
- flush  in  1  exception/eret flush; discards all in-flight writes
- src1_addr, src2_addr  in  5 each  ID source registers
- src1_fwd_ok, src2_fwd_ok  in  1 each  forwarding network can supply the youngest pending value this cycle
- src1_busy, src2_busy  out  1 each  source has a pending write
- ds_stall  out  1  ID must not issue this cycle
- dest_full  out  1  issue_dest counter saturated; ID must not issue
- sb_err  out  1  sticky: retire with zero count or issue at saturation

## Operation
- One counter cnt[r] per register r in 1..NREG-1; cnt[0] constant 0.
- Next-state per r, evaluated in priority order:
  - flush → 0.
  - inc = issue_fire & issue_we & issue_dest==r & r!=0.
  - dec = retire_fire & retire_dest==r & r!=0.
  - inc & dec → unchanged; inc only → +1; dec only → -1.
- Saturation:
  - inc only at max → hold value, set sb_err.
  - dec only at 0 → hold 0, set sb_err.
  - Arithmetic is unsigned CNT_W bits and never wraps.
- Busy, with retire bypass: srcN_busy = (cnt[srcN_addr] − dec_for_srcN) != 0, where dec_for_srcN = retire_fire & retire_dest==srcN_addr & srcN_addr!=0. This mirrors RF write-through, so a register committing this cycle is not busy.
- dest_full = issue_we & issue_dest!=0 & cnt[issue_dest]==max & no retire to issue_dest this cycle.
- ds_stall = (src1_busy & ~src1_fwd_ok) | (src2_busy & ~src2_fwd_ok) | dest_full. Covers load-use and mul/div-result cases.
- sb_err is cleared only by reset.
- flush does not clear sb_err and does not gate same-cycle busy outputs. Outputs reflect pre-flush counters; ID is flushed in the same cycle anyway.

## Timing
- Reset, async on resetn low: all cnt=0, sb_err=0. Hence src*_busy=0, ds_stall=0, dest_full=0, immediately and combinationally.
- resetn deassertion is assumed synchronised upstream. Counters update on the first rising edge after release.
- Counter update latency: 1 cycle. An issue at edge k is visible as busy from cycle k+1.
- Outputs are purely combinational from counters and current inputs; no registered outputs.
- Flush mid-operation: counters read 0 in the cycle after flush. issue_fire/retire_fire in the flush cycle are discarded.
- Simultaneous issue and retire to the same register: net 0, no error even at max or at 0+1.
- Issue/retire to r0: ignored entirely, including for error detection.

## Structure
- Shared package: NREG, CNT_W, GPR address width (5), and CNT_MAX = 2^CNT_W−1.
- Sub-module sb_counter: one saturating up/down counter with inc, dec, clr, and an err pulse. Instantiate it NREG−1 times via generate.
- The top level holds the decoders, read muxes for the two sources and the destination, the stall logic, and the sticky sb_err flop.

## Test plan
- Reset: assert resetn=0 mid-run with cnt[5]=2 → all outputs 0 asynchronously; after release, src1_addr=5 gives src1_busy=0.
- Load-use: issue dest=8 at cycle 0; at cycle 1, src1_addr=8, src1_fwd_ok=0 → ds_stall=1; with src1_fwd_ok=1 → ds_stall=0, src1_busy=1.
- Retire bypass: cnt[3]=1, retire_dest=3 and src2_addr=3 in the same cycle → src2_busy=0; next cycle cnt[3]=0.
- Saturation: three issues to r9 without retire → fourth cycle dest_full=1, ds_stall=1. Forcing issue_fire anyway → cnt holds 3, sb_err=1 and stays set.
- Simultaneous issue and retire: with cnt[4]=3, issue dest=4 and retire dest=4 in the same cycle → cnt[4]=3, dest_full=0, sb_err=0.
- Flush and r0: cnt[2]=2, cnt[7]=1, flush plus issue dest=7 → next cycle all counts 0. Issue/retire dest=0 → no busy and no sb_err.
